// File: rtl/mcyc_pkg.sv
// Shared definitions for the multicycle controller: opcodes, FSM states and
// datapath select encodings.
package mcyc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b001000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_LBRD, S_LBWR, S_SBWR,
    S_RTYPEEX, S_RTYPEWR, S_BEQEX, S_BNEEX, S_JEX, S_ADDIWR
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // A single-beat fetch still needs a one-bit counter.
  function automatic int beatWidth(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/mcyc_beat_ctr.sv
// Fetch beat counter: counts accepted instruction bytes and flags the last one.
module mcyc_beat_ctr
  import mcyc_pkg::*;
#(
  parameter int FETCH_BEATS = 4,
  localparam int BW = beatWidth(FETCH_BEATS)
) (
  input  logic          i_clk,
  input  logic          i_clear,
  input  logic          i_advance,
  output logic [BW-1:0] o_beat,
  output logic          o_last
);

  logic [BW-1:0] r_beat;

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_beat <= '0;
    end else if (i_advance) begin
      r_beat <= r_beat + 1'b1;
    end
  end

  assign o_beat = r_beat;
  assign o_last = (r_beat == BW'(FETCH_BEATS - 1));

endmodule

// File: rtl/mcyc_controller_p.sv
// Multicycle controller with a multi-beat byte-wide instruction fetch and
// optional memory wait states.
module mcyc_controller_p
  import mcyc_pkg::*;
#(
  parameter int FETCH_BEATS = 4,
  parameter int WAIT_EN     = 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [5:0]             i_op,
  input  logic                   i_zero,
  input  logic                   i_mem_ready,
  output logic                   o_memread,
  output logic                   o_memwrite,
  output logic                   o_iord,
  output logic                   o_memtoreg,
  output logic                   o_regwrite,
  output logic                   o_regdst,
  output logic                   o_alusrca,
  output logic [1:0]             o_alusrcb,
  output logic [1:0]             o_aluop,
  output logic [1:0]             o_pcsource,
  output logic [FETCH_BEATS-1:0] o_irwrite,
  output logic                   o_pcen,
  output logic                   o_illegal
);

  localparam int BW = beatWidth(FETCH_BEATS);

  state_t        r_state;
  logic          w_ready;
  logic          w_fetchAdv;
  logic          w_beatClear;
  logic          w_last;
  logic [BW-1:0] w_beat;

  assign w_ready     = (WAIT_EN != 0) ? i_mem_ready : 1'b1;
  assign w_fetchAdv  = (r_state == S_FETCH) && w_ready;
  // Outside FETCH the counter is held at zero so every fetch starts at beat 0.
  assign w_beatClear = i_reset || (r_state != S_FETCH) || (w_fetchAdv && w_last);

  mcyc_beat_ctr #(.FETCH_BEATS(FETCH_BEATS)) u_beatCtr (
    .i_clk     (i_clk),
    .i_clear   (w_beatClear),
    .i_advance (w_fetchAdv),
    .o_beat    (w_beat),
    .o_last    (w_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:   if (w_ready && w_last) r_state <= S_DECODE;
        S_DECODE: begin
          case (i_op)
            OP_LB, OP_SB, OP_ADDI: r_state <= S_MEMADR;
            OP_RTYPE:              r_state <= S_RTYPEEX;
            OP_BEQ:                r_state <= S_BEQEX;
            OP_BNE:                r_state <= S_BNEEX;
            OP_J:                  r_state <= S_JEX;
            default:               r_state <= S_FETCH;
          endcase
        end
        S_MEMADR: begin
          case (i_op)
            OP_LB:   r_state <= S_LBRD;
            OP_SB:   r_state <= S_SBWR;
            OP_ADDI: r_state <= S_ADDIWR;
            default: r_state <= S_FETCH;
          endcase
        end
        S_LBRD:    if (w_ready) r_state <= S_LBWR;
        S_SBWR:    if (w_ready) r_state <= S_FETCH;
        S_RTYPEEX: r_state <= S_RTYPEWR;
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  // Reset masks every output in the cycle it is asserted, whatever the state.
  always_comb begin
    o_memread  = 1'b0;
    o_memwrite = 1'b0;
    o_iord     = 1'b0;
    o_memtoreg = 1'b0;
    o_regwrite = 1'b0;
    o_regdst   = 1'b0;
    o_alusrca  = 1'b0;
    o_alusrcb  = SRCB_REG;
    o_aluop    = ALUOP_ADD;
    o_pcsource = PC_ALU;
    o_irwrite  = '0;
    o_pcen     = 1'b0;
    o_illegal  = 1'b0;
    if (!i_reset) begin
      case (r_state)
        S_FETCH: begin
          o_memread = 1'b1;
          o_alusrcb = SRCB_FOUR;
          o_irwrite = FETCH_BEATS'(w_ready) << w_beat;
          o_pcen    = w_ready;
        end
        S_DECODE: begin
          o_alusrcb = SRCB_BR;
          case (i_op)
            OP_LB, OP_SB, OP_ADDI, OP_RTYPE, OP_BEQ, OP_BNE, OP_J: o_illegal = 1'b0;
            default: o_illegal = 1'b1;
          endcase
        end
        S_MEMADR: begin
          o_alusrca = 1'b1;
          o_alusrcb = SRCB_IMM;
        end
        S_LBRD: begin
          o_memread = 1'b1;
          o_iord    = 1'b1;
        end
        S_LBWR: begin
          o_regwrite = 1'b1;
          o_memtoreg = 1'b1;
        end
        S_SBWR: begin
          o_memwrite = 1'b1;
          o_iord     = 1'b1;
        end
        S_ADDIWR:  o_regwrite = 1'b1;
        S_RTYPEEX: begin
          o_alusrca = 1'b1;
          o_aluop   = ALUOP_FUNCT;
        end
        S_RTYPEWR: begin
          o_regwrite = 1'b1;
          o_regdst   = 1'b1;
        end
        S_BEQEX, S_BNEEX: begin
          o_alusrca  = 1'b1;
          o_aluop    = ALUOP_SUB;
          o_pcsource = PC_ALUOUT;
          o_pcen     = (r_state == S_BEQEX) ? i_zero : ~i_zero;
        end
        S_JEX: begin
          o_pcsource = PC_JUMP;
          o_pcen     = 1'b1;
        end
        default: o_illegal = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mcyc_controller_p.sv
// Self-checking bench for mcyc_controller_p: table-driven instruction runs plus
// hand-written stall/reset sequences on three differently parameterised copies.
`timescale 1ns/1ps
module tb_mcyc_controller_p;

  typedef struct packed {
    logic       memread, memwrite, iord, memtoreg, regwrite, regdst, alusrca;
    logic [1:0] alusrcb, aluop, pcsource;
    logic [3:0] irwrite;
    logic       pcen, illegal;
  } ctl_t;

  typedef struct {
    logic [5:0] op;
    logic       zero;
    string      name;
  } vec_t;

  typedef enum int {
    K_FETCH, K_FSTALL, K_DECODE, K_ILLEGAL, K_MEMADR, K_LBRD, K_LBWR, K_SBWR,
    K_ADDIWR, K_RTEX, K_RTWR, K_BRTAKEN, K_BRNOT, K_JEX
  } kind_t;

  localparam logic [5:0] T_LB = 6'b100000, T_SB = 6'b101000, T_RT = 6'b000000;
  localparam logic [5:0] T_BEQ = 6'b000010, T_BNE = 6'b000011, T_J = 6'b001000;
  localparam logic [5:0] T_ADDI = 6'b000100, T_BAD = 6'b111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] op = 6'b0;
  logic       zero = 1'b0;
  logic       rstA = 1'b1, rdyA = 1'b1;
  logic       rstB = 1'b1, rdyB = 1'b1;
  logic       rstC = 1'b1;
  logic       rdyC = 1'b0;

  logic       mrA, mwA, iordA, mtrA, rwA, rdA, asaA, pcenA, illA;
  logic [1:0] asbA, aopA, pcsA;
  logic [3:0] irA;
  logic       mrB, mwB, iordB, mtrB, rwB, rdB, asaB, pcenB, illB;
  logic [1:0] asbB, aopB, pcsB;
  logic [1:0] irB;
  logic       mrC, mwC, iordC, mtrC, rwC, rdC, asaC, pcenC, illC;
  logic [1:0] asbC, aopC, pcsC;
  logic [3:0] irC;

  ctl_t actA, actB, actC;
  assign actA = {mrA, mwA, iordA, mtrA, rwA, rdA, asaA, asbA, aopA, pcsA, irA, pcenA, illA};
  assign actB = {mrB, mwB, iordB, mtrB, rwB, rdB, asaB, asbB, aopB, pcsB, 2'b00, irB, pcenB, illB};
  assign actC = {mrC, mwC, iordC, mtrC, rwC, rdC, asaC, asbC, aopC, pcsC, irC, pcenC, illC};

  mcyc_controller_p #(.FETCH_BEATS(4), .WAIT_EN(1)) dutA (
    .i_clk(clk), .i_reset(rstA), .i_op(op), .i_zero(zero), .i_mem_ready(rdyA),
    .o_memread(mrA), .o_memwrite(mwA), .o_iord(iordA), .o_memtoreg(mtrA),
    .o_regwrite(rwA), .o_regdst(rdA), .o_alusrca(asaA), .o_alusrcb(asbA),
    .o_aluop(aopA), .o_pcsource(pcsA), .o_irwrite(irA), .o_pcen(pcenA), .o_illegal(illA)
  );

  mcyc_controller_p #(.FETCH_BEATS(2), .WAIT_EN(1)) dutB (
    .i_clk(clk), .i_reset(rstB), .i_op(op), .i_zero(zero), .i_mem_ready(rdyB),
    .o_memread(mrB), .o_memwrite(mwB), .o_iord(iordB), .o_memtoreg(mtrB),
    .o_regwrite(rwB), .o_regdst(rdB), .o_alusrca(asaB), .o_alusrcb(asbB),
    .o_aluop(aopB), .o_pcsource(pcsB), .o_irwrite(irB), .o_pcen(pcenB), .o_illegal(illB)
  );

  mcyc_controller_p #(.FETCH_BEATS(4), .WAIT_EN(0)) dutC (
    .i_clk(clk), .i_reset(rstC), .i_op(op), .i_zero(zero), .i_mem_ready(rdyC),
    .o_memread(mrC), .o_memwrite(mwC), .o_iord(iordC), .o_memtoreg(mtrC),
    .o_regwrite(rwC), .o_regdst(rdC), .o_alusrca(asaC), .o_alusrcb(asbC),
    .o_aluop(aopC), .o_pcsource(pcsC), .o_irwrite(irC), .o_pcen(pcenC), .o_illegal(illC)
  );

  ctl_t  expQ[$];
  string tagQ[$];
  int    nChecks = 0;
  int    nPass = 0;

  // Expected control word for each kind of cycle, taken from the state output table.
  function automatic ctl_t mkW(input kind_t k, input int beat);
    ctl_t w = '0;
    case (k)
      K_FETCH:   begin w.memread = 1; w.alusrcb = 2'b01; w.irwrite = 4'(1 << beat); w.pcen = 1; end
      K_FSTALL:  begin w.memread = 1; w.alusrcb = 2'b01; end
      K_DECODE:  w.alusrcb = 2'b11;
      K_ILLEGAL: begin w.alusrcb = 2'b11; w.illegal = 1; end
      K_MEMADR:  begin w.alusrca = 1; w.alusrcb = 2'b10; end
      K_LBRD:    begin w.memread = 1; w.iord = 1; end
      K_LBWR:    begin w.regwrite = 1; w.memtoreg = 1; end
      K_SBWR:    begin w.memwrite = 1; w.iord = 1; end
      K_ADDIWR:  w.regwrite = 1;
      K_RTEX:    begin w.alusrca = 1; w.aluop = 2'b10; end
      K_RTWR:    begin w.regwrite = 1; w.regdst = 1; end
      K_BRTAKEN: begin w.alusrca = 1; w.aluop = 2'b01; w.pcsource = 2'b01; w.pcen = 1; end
      K_BRNOT:   begin w.alusrca = 1; w.aluop = 2'b01; w.pcsource = 2'b01; end
      K_JEX:     begin w.pcsource = 2'b10; w.pcen = 1; end
      default:   w = '0;
    endcase
    return w;
  endfunction

  task automatic checkOutput(input int d);
    ctl_t  exp, act;
    string tag;
    exp = expQ.pop_front();
    tag = tagQ.pop_front();
    case (d)
      0:       act = actA;
      1:       act = actB;
      default: act = actC;
    endcase
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Drives one cycle's inputs just after the rising edge and checks at the falling edge.
  task automatic applyStimulus(input int d, input logic rst, input logic rdy,
                               input logic [5:0] o, input logic z,
                               input ctl_t exp, input string tag);
    @(posedge clk);
    #1;
    op   = o;
    zero = z;
    case (d)
      0:       begin rstA = rst; rdyA = rdy; end
      1:       begin rstB = rst; rdyB = rdy; end
      default: rstC = rst;
    endcase
    expQ.push_back(exp);
    tagQ.push_back(tag);
    @(negedge clk);
    checkOutput(d);
  endtask

  task automatic runInstr(input int d, input logic [5:0] o, input logic z, input string name);
    kind_t tail[$];
    for (int b = 0; b < 4; b++)
      applyStimulus(d, 1'b0, 1'b1, o, z, mkW(K_FETCH, b), $sformatf("%s beat%0d", name, b));
    case (o)
      T_LB:    begin tail.push_back(K_DECODE); tail.push_back(K_MEMADR); tail.push_back(K_LBRD); tail.push_back(K_LBWR); end
      T_SB:    begin tail.push_back(K_DECODE); tail.push_back(K_MEMADR); tail.push_back(K_SBWR); end
      T_ADDI:  begin tail.push_back(K_DECODE); tail.push_back(K_MEMADR); tail.push_back(K_ADDIWR); end
      T_RT:    begin tail.push_back(K_DECODE); tail.push_back(K_RTEX); tail.push_back(K_RTWR); end
      T_BEQ:   begin tail.push_back(K_DECODE); tail.push_back(z ? K_BRTAKEN : K_BRNOT); end
      T_BNE:   begin tail.push_back(K_DECODE); tail.push_back(z ? K_BRNOT : K_BRTAKEN); end
      T_J:     begin tail.push_back(K_DECODE); tail.push_back(K_JEX); end
      default: tail.push_back(K_ILLEGAL);
    endcase
    foreach (tail[i])
      applyStimulus(d, 1'b0, 1'b1, o, z, mkW(tail[i], 0), $sformatf("%s %s", name, tail[i].name()));
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{T_LB,   1'b0, "LB"};
    vecs[1] = '{T_SB,   1'b0, "SB"};
    vecs[2] = '{T_ADDI, 1'b1, "ADDI"};
    vecs[3] = '{T_RT,   1'b0, "RTYPE"};
    vecs[4] = '{T_BEQ,  1'b0, "BEQ z0"};
    vecs[5] = '{T_BAD,  1'b0, "ILLEGAL"};
    vecs[6] = '{T_BEQ,  1'b1, "BEQ z1"};
    vecs[7] = '{T_BNE,  1'b0, "BNE z0"};
    vecs[8] = '{T_BNE,  1'b1, "BNE z1"};
    vecs[9] = '{T_J,    1'b1, "J"};

    applyStimulus(0, 1'b1, 1'b1, T_LB, 1'b0, '0, "A reset 0");
    applyStimulus(0, 1'b1, 1'b1, T_LB, 1'b1, '0, "A reset 1");

    for (int i = 0; i < 10; i++) runInstr(0, vecs[i].op, vecs[i].zero, vecs[i].name);
    applyStimulus(0, 1'b0, 1'b1, T_LB, 1'b0, mkW(K_FETCH, 0), "after J beat0");
    applyStimulus(0, 1'b1, 1'b1, T_LB, 1'b0, '0, "reset mid-fetch");

    // Fetch stall, then a load stalled in LBRD while op wanders.
    applyStimulus(0, 1'b0, 1'b1, T_LB, 1'b0, mkW(K_FETCH, 0), "stallLB beat0");
    applyStimulus(0, 1'b0, 1'b1, T_LB, 1'b0, mkW(K_FETCH, 1), "stallLB beat1");
    applyStimulus(0, 1'b0, 1'b0, T_LB, 1'b0, mkW(K_FSTALL, 0), "stallLB beat2 wait");
    applyStimulus(0, 1'b0, 1'b1, T_LB, 1'b0, mkW(K_FETCH, 2), "stallLB beat2");
    applyStimulus(0, 1'b0, 1'b1, T_LB, 1'b0, mkW(K_FETCH, 3), "stallLB beat3");
    applyStimulus(0, 1'b0, 1'b1, T_LB, 1'b0, mkW(K_DECODE, 0), "stallLB decode");
    applyStimulus(0, 1'b0, 1'b1, T_LB, 1'b0, mkW(K_MEMADR, 0), "stallLB memadr");
    applyStimulus(0, 1'b0, 1'b0, T_LB, 1'b0, mkW(K_LBRD, 0), "stallLB rd wait0");
    applyStimulus(0, 1'b0, 1'b0, T_J,  1'b0, mkW(K_LBRD, 0), "stallLB rd wait1");
    applyStimulus(0, 1'b0, 1'b1, T_J,  1'b0, mkW(K_LBRD, 0), "stallLB rd done");
    applyStimulus(0, 1'b0, 1'b1, T_J,  1'b0, mkW(K_LBWR, 0), "stallLB wr");
    applyStimulus(0, 1'b0, 1'b1, T_J,  1'b0, mkW(K_FETCH, 0), "stallLB next beat0");
    applyStimulus(0, 1'b1, 1'b1, T_SB, 1'b0, '0, "reset mid-J");

    // Reset arriving while a store waits on memory.
    for (int b = 0; b < 4; b++)
      applyStimulus(0, 1'b0, 1'b1, T_SB, 1'b0, mkW(K_FETCH, b), $sformatf("rstSB beat%0d", b));
    applyStimulus(0, 1'b0, 1'b1, T_SB, 1'b0, mkW(K_DECODE, 0), "rstSB decode");
    applyStimulus(0, 1'b0, 1'b1, T_SB, 1'b0, mkW(K_MEMADR, 0), "rstSB memadr");
    applyStimulus(0, 1'b0, 1'b0, T_SB, 1'b0, mkW(K_SBWR, 0), "rstSB wait0");
    applyStimulus(0, 1'b0, 1'b0, T_SB, 1'b0, mkW(K_SBWR, 0), "rstSB wait1");
    applyStimulus(0, 1'b1, 1'b0, T_SB, 1'b0, '0, "rstSB reset");
    applyStimulus(0, 1'b0, 1'b1, T_SB, 1'b0, mkW(K_FETCH, 0), "rstSB beat0 after");
    applyStimulus(0, 1'b0, 1'b1, T_SB, 1'b0, mkW(K_FETCH, 1), "rstSB beat1 after");
    applyStimulus(0, 1'b1, 1'b1, T_SB, 1'b0, '0, "A parked");

    // Two-beat fetch with a three-cycle wait on the final beat.
    applyStimulus(1, 1'b0, 1'b1, T_J, 1'b0, mkW(K_FETCH, 0), "B beat0");
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 1'b0, 1'b0, T_J, 1'b0, mkW(K_FSTALL, 0), $sformatf("B beat1 wait%0d", i));
    applyStimulus(1, 1'b0, 1'b1, T_J, 1'b0, mkW(K_FETCH, 1), "B beat1");
    applyStimulus(1, 1'b0, 1'b1, T_J, 1'b0, mkW(K_DECODE, 0), "B decode");
    applyStimulus(1, 1'b0, 1'b1, T_J, 1'b0, mkW(K_JEX, 0), "B jex");
    applyStimulus(1, 1'b0, 1'b1, T_J, 1'b0, mkW(K_FETCH, 0), "B next beat0");
    applyStimulus(1, 1'b1, 1'b1, T_J, 1'b0, '0, "B parked");

    // Wait states disabled: mem_ready is tied low yet ADDI completes in 7 cycles.
    runInstr(2, T_ADDI, 1'b0, "C ADDI");
    applyStimulus(2, 1'b0, 1'b1, T_ADDI, 1'b0, mkW(K_FETCH, 0), "C next beat0");
    applyStimulus(2, 1'b1, 1'b1, T_ADDI, 1'b0, '0, "C parked");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
